// File: rtl/hazard_pkg.sv
// Shared types for the hazard controller: forwarding selects, result-source encoding, counter width.
package hazard_pkg;

  typedef enum logic [1:0] {
    EXECUTE_RD        = 2'b00,
    WRITE_BACK_RESULT = 2'b01,
    MEMORY_ALU_RESULT = 2'b10
  } hazard_forward_a_t;

  // Operand B uses the same encoding as operand A.
  typedef hazard_forward_a_t hazard_forward_b_t;

  localparam logic [1:0] RESULT_SRC_MEM = 2'b01;

  // In-flight long-op counter width; enough for MAX_LONG_OPS up to 15.
  localparam int CNT_W = 4;

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register pending tracker and outstanding-count for variable-latency long ops.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter int MAX_LONG_OPS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic                  LongOpE,
  input  logic                  cntInc,
  input  logic                  setEn,
  input  logic [REG_ADDR_W-1:0] RdE,
  input  logic                  LongDoneValid,
  input  logic [REG_ADDR_W-1:0] LongDoneRd,
  output logic                  pendRs1,
  output logic                  pendRs2,
  output logic                  full
);

  localparam int NREG = 1 << REG_ADDR_W;
  localparam logic [CNT_W-1:0] MAXC = CNT_W'(MAX_LONG_OPS);

  logic [NREG-1:0]  pending, pendingNxt;
  logic [CNT_W-1:0] count, countNxt;

  assign pendRs1 = pending[Rs1D];
  assign pendRs2 = pending[Rs2D];
  // A returning result frees a slot in the same cycle, so it cancels the full condition.
  assign full    = LongOpE && (count == MAXC) && !LongDoneValid;

  // Next pending vector and count: clear before set so a same-cycle set wins; x0 never pends.
  always_comb begin
    pendingNxt = pending;
    if (LongDoneValid) pendingNxt[LongDoneRd] = 1'b0;
    if (setEn)         pendingNxt[RdE]        = 1'b1;
    pendingNxt[0] = 1'b0;

    countNxt = count;
    if (cntInc && !LongDoneValid && count != MAXC)
      countNxt = count + 1'b1;
    else if (!cntInc && LongDoneValid && count != '0)
      countNxt = count - 1'b1;
  end

  // Tracking state; reset discards every outstanding op.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
      count   <= '0;
    end else begin
      pending <= pendingNxt;
      count   <= countNxt;
    end
  end

`ifndef SYNTHESIS
  // A result returning with nothing outstanding indicates a broken long unit.
  always_ff @(posedge clk) begin
    if (!reset && LongDoneValid)
      assert (count != '0) else $error("hazard_scoreboard: LongDoneValid with no long op outstanding");
  end
`endif

endmodule

// File: rtl/hazard_ctrl_sb.sv
// Pipeline hazard controller with long-op scoreboard and memory-wait freeze.
// Optional macro HAZARD_PERF_CNT_EN adds StallCycles/FlushEvents performance counters.
module hazard_ctrl_sb
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter int MAX_LONG_OPS = 2,
  parameter int PERF_CNT_W   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] Rs1E,
  input  logic [REG_ADDR_W-1:0] Rs2E,
  input  logic [REG_ADDR_W-1:0] RdE,
  input  logic [REG_ADDR_W-1:0] RdM,
  input  logic [REG_ADDR_W-1:0] RdW,
  input  logic                  RegWriteE,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic [1:0]            ResultSrcE,
  input  logic                  PCSrcE,
  input  logic                  LongOpE,
  input  logic                  LongDoneValid,
  input  logic [REG_ADDR_W-1:0] LongDoneRd,
  input  logic                  MemReadyM,
  output hazard_forward_a_t     ForwardAE,
  output hazard_forward_b_t     ForwardBE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  StallM,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushM,
  output logic                  FlushW
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [PERF_CNT_W-1:0] StallCycles,
  output logic [PERF_CNT_W-1:0] FlushEvents
`endif
);

  if (MAX_LONG_OPS < 1 || MAX_LONG_OPS > 15 || PERF_CNT_W < 1) begin : g_param_check
    $error("hazard_ctrl_sb: parameter out of range");
  end

  logic lu, sb, pendRs1, pendRs2, full, issue, cntInc;

  function automatic hazard_forward_a_t fwdSel(
    input logic [REG_ADDR_W-1:0] rs,
    input logic [REG_ADDR_W-1:0] rdM,
    input logic                  wrM,
    input logic [REG_ADDR_W-1:0] rdW,
    input logic                  wrW
  );
    if (rs != '0 && rs == rdM && wrM)      return MEMORY_ALU_RESULT;
    else if (rs != '0 && rs == rdW && wrW) return WRITE_BACK_RESULT;
    else                                   return EXECUTE_RD;
  endfunction

  assign ForwardAE = reset ? EXECUTE_RD : fwdSel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
  assign ForwardBE = reset ? EXECUTE_RD : fwdSel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);

  assign lu = (ResultSrcE == RESULT_SRC_MEM) && RegWriteE && (RdE != '0) &&
              ((Rs1D == RdE) || (Rs2D == RdE));
  assign sb = pendRs1 || pendRs2;

  // A long op is accepted only when E advances; x0 destinations count but never pend.
  assign cntInc = LongOpE && !StallE;
  assign issue  = cntInc && (RdE != '0);

  hazard_scoreboard #(
    .REG_ADDR_W  (REG_ADDR_W),
    .MAX_LONG_OPS(MAX_LONG_OPS)
  ) u_sb (
    .clk          (clk),
    .reset        (reset),
    .Rs1D         (Rs1D),
    .Rs2D         (Rs2D),
    .LongOpE      (LongOpE),
    .cntInc       (cntInc),
    .setEn        (issue),
    .RdE          (RdE),
    .LongDoneValid(LongDoneValid),
    .LongDoneRd   (LongDoneRd),
    .pendRs1      (pendRs1),
    .pendRs2      (pendRs2),
    .full         (full)
  );

  // Prioritised stall/flush: memory wait freezes everything, then long-op overflow, branch, data hazards.
  always_comb begin
    StallF = 1'b0; StallD = 1'b0; StallE = 1'b0; StallM = 1'b0;
    FlushD = 1'b0; FlushE = 1'b0; FlushM = 1'b0; FlushW = 1'b0;
    if (reset) begin
      FlushD = 1'b1; FlushE = 1'b1; FlushM = 1'b1; FlushW = 1'b1;
    end else if (!MemReadyM) begin
      StallF = 1'b1; StallD = 1'b1; StallE = 1'b1; StallM = 1'b1;
      FlushW = 1'b1;
    end else if (full) begin
      StallF = 1'b1; StallD = 1'b1; StallE = 1'b1;
      FlushM = 1'b1;
    end else if (PCSrcE) begin
      // Decode holds a wrong-path instruction, so its hazards are irrelevant.
      FlushD = 1'b1; FlushE = 1'b1;
    end else if (lu || sb) begin
      StallF = 1'b1; StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic flushTaken;
  assign flushTaken = !reset && MemReadyM && !full && PCSrcE;

  // Free-running stall-cycle and branch-flush counters, wrapping naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      StallCycles <= '0;
      FlushEvents <= '0;
    end else begin
      if (StallD)     StallCycles <= StallCycles + 1'b1;
      if (flushTaken) FlushEvents <= FlushEvents + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl_sb.sv
// Directed scoreboard bench for hazard_ctrl_sb (default build, MAX_LONG_OPS=2).
module tb_hazard_ctrl_sb;
  import hazard_pkg::*;

  localparam int RW = 5;

  logic clk = 1'b0;
  logic reset;
  logic [RW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, LongDoneRd;
  logic RegWriteE, RegWriteM, RegWriteW, PCSrcE, LongOpE, LongDoneValid, MemReadyM;
  logic [1:0] ResultSrcE;
  hazard_forward_a_t ForwardAE;
  hazard_forward_b_t ForwardBE;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] StallCycles, FlushEvents;
`endif

  always #5 clk = ~clk;

  hazard_ctrl_sb #(.REG_ADDR_W(RW), .MAX_LONG_OPS(2), .PERF_CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .LongOpE(LongOpE),
    .LongDoneValid(LongDoneValid), .LongDoneRd(LongDoneRd), .MemReadyM(MemReadyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW)
`ifdef HAZARD_PERF_CNT_EN
    , .StallCycles(StallCycles), .FlushEvents(FlushEvents)
`endif
  );

  typedef struct {
    string       tag;
    logic [11:0] exp;
  } exp_t;

  exp_t sbq[$];
  int nVec = 0;
  int nErr = 0;

  task automatic idle();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
    RdE = '0; RdM = '0; RdW = '0; LongDoneRd = '0;
    RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    ResultSrcE = 2'b00; PCSrcE = 1'b0; LongOpE = 1'b0;
    LongDoneValid = 1'b0; MemReadyM = 1'b1;
  endtask

  task automatic nxt();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Expected outputs as {ForwardAE, ForwardBE, StallF/D/E/M, FlushD/E/M/W}.
  task automatic push(string tag, hazard_forward_a_t fa, hazard_forward_a_t fb,
                      logic [3:0] st, logic [3:0] fl);
    exp_t e;
    e.tag = tag;
    e.exp = {fa, fb, st, fl};
    sbq.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    logic [11:0] act;
    #1;
    act = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW};
    e = sbq.pop_front();
    nVec++;
    assert (act === e.exp) else begin
      nErr++;
      $error("FAIL %s observed=%03h expected=%03h", e.tag, act, e.exp);
    end
  endtask

  task automatic step(string tag, hazard_forward_a_t fa, hazard_forward_a_t fb,
                      logic [3:0] st, logic [3:0] fl);
    push(tag, fa, fb, st, fl);
    check();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    @(negedge clk);
    // Reset forces flushes and suppresses forwarding even with a live M match.
    RdM = 5; RegWriteM = 1'b1; Rs1E = 5;
    step("rst_out", EXECUTE_RD, EXECUTE_RD, 4'b0000, 4'b1111);
    nxt(); reset = 1'b0; idle();
    step("idle", EXECUTE_RD, EXECUTE_RD, 4'b0000, 4'b0000);

    // Forwarding
    RdM = 5; RegWriteM = 1'b1; Rs1E = 5;
    step("fwdA_mem", MEMORY_ALU_RESULT, EXECUTE_RD, 4'b0000, 4'b0000);
    RdM = 0; Rs1E = 0; RdW = 0; RegWriteW = 1'b1;
    step("fwdA_x0", EXECUTE_RD, EXECUTE_RD, 4'b0000, 4'b0000);
    RdM = 3; RegWriteM = 1'b1; RdW = 3; RegWriteW = 1'b1; Rs2E = 3;
    step("fwdB_mprio", EXECUTE_RD, MEMORY_ALU_RESULT, 4'b0000, 4'b0000);
    RegWriteM = 1'b0;
    step("fwdB_wb", EXECUTE_RD, WRITE_BACK_RESULT, 4'b0000, 4'b0000);

    // Load-use: one stall cycle, then forwarded from M
    idle();
    ResultSrcE = RESULT_SRC_MEM; RegWriteE = 1'b1; RdE = 7; Rs2D = 7;
    step("lu", EXECUTE_RD, EXECUTE_RD, 4'b1100, 4'b0100);
    nxt(); idle();
    RdM = 7; RegWriteM = 1'b1; Rs2E = 7; Rs2D = 7;
    step("lu_next", EXECUTE_RD, MEMORY_ALU_RESULT, 4'b0000, 4'b0000);

    // Long op to x9, consumer arrives three cycles later
    nxt(); idle();
    LongOpE = 1'b1; RdE = 9;
    step("long_issue", EXECUTE_RD, EXECUTE_RD, 4'b0000, 4'b0000);
    for (int i = 0; i < 2; i++) begin
      nxt(); idle();
      step("long_wait", EXECUTE_RD, EXECUTE_RD, 4'b0000, 4'b0000);
    end
    nxt(); idle(); Rs1D = 9;
    step("sb_hold", EXECUTE_RD, EXECUTE_RD, 4'b1100, 4'b0100);
    nxt(); idle(); Rs1D = 9;
    step("sb_hold2", EXECUTE_RD, EXECUTE_RD, 4'b1100, 4'b0100);
    nxt(); idle(); Rs1D = 9; LongDoneValid = 1'b1; LongDoneRd = 9;
    step("sb_done", EXECUTE_RD, EXECUTE_RD, 4'b1100, 4'b0100);
    nxt(); idle(); Rs1D = 9;
    step("sb_release", EXECUTE_RD, EXECUTE_RD, 4'b0000, 4'b0000);

    // Outstanding-op limit
    nxt(); idle(); LongOpE = 1'b1; RdE = 10;
    step("full_i1", EXECUTE_RD, EXECUTE_RD, 4'b0000, 4'b0000);
    nxt(); idle(); LongOpE = 1'b1; RdE = 11;
    step("full_i2", EXECUTE_RD, EXECUTE_RD, 4'b0000, 4'b0000);
    nxt(); idle(); LongOpE = 1'b1; RdE = 12;
    step("full", EXECUTE_RD, EXECUTE_RD, 4'b1110, 4'b0010);
    nxt(); idle(); LongOpE = 1'b1; RdE = 12; LongDoneValid = 1'b1; LongDoneRd = 10;
    step("full_done", EXECUTE_RD, EXECUTE_RD, 4'b0000, 4'b0000);
    nxt(); idle(); LongDoneValid = 1'b1; LongDoneRd = 11; Rs2D = 12;
    step("sb_rs2", EXECUTE_RD, EXECUTE_RD, 4'b1100, 4'b0100);
    nxt(); idle(); LongDoneValid = 1'b1; LongDoneRd = 12; Rs1D = 10;
    step("drain", EXECUTE_RD, EXECUTE_RD, 4'b0000, 4'b0000);

    // Memory wait beats branch, branch beats load-use
    nxt(); idle(); MemReadyM = 1'b0; PCSrcE = 1'b1;
    step("memwait", EXECUTE_RD, EXECUTE_RD, 4'b1111, 4'b0001);
    nxt(); idle(); PCSrcE = 1'b1;
    ResultSrcE = RESULT_SRC_MEM; RegWriteE = 1'b1; RdE = 7; Rs1D = 7;
    step("branch", EXECUTE_RD, EXECUTE_RD, 4'b0000, 4'b1100);

    // Reset mid long op discards pending bit and count
    nxt(); idle(); LongOpE = 1'b1; RdE = 9;
    step("rst_issue", EXECUTE_RD, EXECUTE_RD, 4'b0000, 4'b0000);
    nxt(); idle(); reset = 1'b1;
    step("rst_again", EXECUTE_RD, EXECUTE_RD, 4'b0000, 4'b1111);
    nxt(); reset = 1'b0; idle(); Rs1D = 9;
    step("rst_pend", EXECUTE_RD, EXECUTE_RD, 4'b0000, 4'b0000);
    nxt(); idle(); LongOpE = 1'b1; RdE = 14;
    step("rst_cnt1", EXECUTE_RD, EXECUTE_RD, 4'b0000, 4'b0000);
    nxt(); idle(); LongOpE = 1'b1; RdE = 15;
    step("rst_cnt2", EXECUTE_RD, EXECUTE_RD, 4'b0000, 4'b0000);
    nxt(); idle(); LongOpE = 1'b1; RdE = 16;
    step("full_again", EXECUTE_RD, EXECUTE_RD, 4'b1110, 4'b0010);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_sb.md
Name: hazard_ctrl_sb

Overview:
Second-generation pipeline hazard controller for the 5-stage RISC-V core. Forwarding select, load-use stall and branch flush are combinational, so they act in the same cycle as the hazard. Adds a per-register scoreboard for variable-latency long ops (mul/div), an outstanding-op limit, and a global freeze on data-memory wait. Sits beside the datapath and drives the stall and flush inputs of every pipeline register.

Parameters:
REG_ADDR_W, 5, register-index width; register count is 2**REG_ADDR_W.
MAX_LONG_OPS, 2, maximum in-flight long ops (range 1..15).
PERF_CNT_W, 32, performance-counter width (used only with the optional feature).

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high
Rs1D, Rs2D  in  REG_ADDR_W  decode-stage source registers
Rs1E, Rs2E, RdE  in  REG_ADDR_W  execute-stage sources and destination
RdM, RdW  in  REG_ADDR_W  memory- and writeback-stage destinations
RegWriteE, RegWriteM, RegWriteW  in  1  stage writes a register
ResultSrcE  in  2  execute result select; RESULT_SRC_MEM marks a load
PCSrcE  in  1  taken branch or jump resolved in E
LongOpE  in  1  instruction in E is a long op writing RdE
LongDoneValid  in  1  long unit returns a result this cycle
LongDoneRd  in  REG_ADDR_W  destination of the returning result
MemReadyM  in  1  data memory completes the access in M
ForwardAE  out  hazard_forward_a_t  ALU operand A select
ForwardBE  out  hazard_forward_b_t  ALU operand B select
StallF, StallD, StallE, StallM  out  1  hold the stage register
FlushD, FlushE, FlushM, FlushW  out  1  bubble the stage register

Behaviour:
- All outputs are combinational from inputs and state; there is no output latency.
- Forwarding, per operand: select MEMORY_ALU_RESULT if Rs==RdM, RegWriteM and Rs!=0; else WRITE_BACK_RESULT if Rs==RdW, RegWriteW and Rs!=0; else EXECUTE_RD. M has priority over W.
- lu (load-use) = ResultSrcE==RESULT_SRC_MEM & RegWriteE & RdE!=0 & (Rs1D==RdE | Rs2D==RdE).
- sb (scoreboard hit) = pending[Rs1D] | pending[Rs2D]. pending[0] is hard-wired 0.
- full = LongOpE & count==MAX_LONG_OPS & !LongDoneValid.
- Priority, highest first:
  1. !MemReadyM: StallF, StallD, StallE, StallM = 1; FlushW = 1; all other flushes 0.
  2. full: StallF, StallD, StallE = 1; FlushM = 1.
  3. PCSrcE: FlushD, FlushE = 1; lu and sb are ignored because the D instruction is wrong-path.
  4. lu | sb: StallF, StallD = 1; FlushE = 1.
  5. Otherwise all stalls and flushes are 0.
- issue = LongOpE & RdE!=0 & !StallE. RdE==0 never sets a pending bit; the op still counts in count.
- Scoreboard update, clocked:
  - issue sets pending[RdE].
  - LongDoneValid clears pending[LongDoneRd].
  - If the same register is set and cleared in one cycle, set wins.
- count: +1 on (LongOpE & !StallE), -1 on LongDoneValid, unchanged if both occur. It never exceeds MAX_LONG_OPS.
- LongDoneValid with count==0 is illegal; assertion only, and count saturates at 0.
- Reset, synchronous:
  - pending and count are cleared.
  - While reset is high: all stalls 0, FlushD/E/M/W = 1, ForwardAE/BE = EXECUTE_RD.
  - Reset mid long op discards all tracking.

Optional Feature:
HAZARD_PERF_CNT_EN.
- Defined: adds outputs StallCycles and FlushEvents, each PERF_CNT_W bits.
  - StallCycles increments on every cycle with StallD==1.
  - FlushEvents increments on every cycle with PCSrcE taking effect (priority 3).
  - Both counters wrap modulo 2**PERF_CNT_W and clear on reset.
- Undefined: these ports and registers do not exist.

Decomposition:
- hazard_pkg: hazard_forward_a_t / hazard_forward_b_t enums (EXECUTE_RD*, MEMORY_ALU_RESULT, WRITE_BACK_RESULT) and RESULT_SRC_MEM = 2'b01.
- Sub-module hazard_scoreboard (params REG_ADDR_W, MAX_LONG_OPS) holds the pending vector and count; it outputs pending lookups and full.
- hazard_ctrl_sb holds forwarding, priority logic and the optional counters.

Test Plan:
- add x5 in M, Rs1E=5, RegWriteM=1 -> ForwardAE=MEMORY_ALU_RESULT in the same cycle; with Rs1E=0 -> EXECUTE_RD.
- Load to x7 in E, Rs2D=7 -> StallF=StallD=FlushE=1 for exactly one cycle; next cycle the load is in M and ForwardBE=MEMORY_ALU_RESULT.
- Long op to x9 issues; three cycles later Rs1D=9 -> StallD held until LongDoneValid with LongDoneRd=9, released the following cycle.
- MAX_LONG_OPS=2: two ops in flight plus LongOpE -> StallE=FlushM=1; LongDoneValid same cycle -> no stall.
- MemReadyM=0 together with PCSrcE=1 -> all stalls 1, FlushW=1, FlushD=0; flush applies once MemReadyM=1.
- Reset asserted with pending[9] set -> after reset, Rs1D=9 causes no stall and count==0.
